exit_controller: RTL and testbench

- Exit-side counterpart of the entry checker. Owns the 8-slot occupancy register, `parking_capacity`, where bit i = 1 means slot i is free. The entry checker reads this register.
- Serves car-exit requests: validates the slot, runs the exit-gate timing FSM, then frees the slot.
- Also accepts entry claims so the capacity register stays the single source of truth.

---
 rtl/parking_pkg.sv | 19 +
 rtl/exit_controller_slot_register.sv | 42 ++++
 rtl/exit_controller.sv | 107 ++++++++++
 tb/tb_exit_controller.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot slot logic.
// Holds the default sizing, the exit FSM state encoding and the reset value
// of the free-slot bitmap.
package parking_pkg;

    localparam int SLOTS       = 8;
    localparam int SLOT_W      = 3;
    localparam int GATE_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        OPEN    = 2'd2,
        RELEASE = 2'd3
    } exit_state_t;

    localparam logic [SLOTS-1:0] ALL_FREE = {SLOTS{1'b1}};

endpackage

// File: rtl/exit_controller_slot_register.sv
// slot_register: free-slot bitmap (bit i = 1 means slot i is free).
// Ports:
//   clk, rst            - clock, synchronous active-high reset (-> all free)
//   rel, rel_slot       - mark rel_slot free
//   claim, claim_slot   - mark claim_slot occupied
//   capacity            - registered bitmap
// A release and a claim in the same cycle are applied release first, so a
// claim on the slot being released leaves it occupied.
module slot_register
    import parking_pkg::*;
#(
    parameter int SLOTS  = parking_pkg::SLOTS,
    parameter int SLOT_W = parking_pkg::SLOT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rel,
    input  logic [SLOT_W-1:0] rel_slot,
    input  logic              claim,
    input  logic [SLOT_W-1:0] claim_slot,
    output logic [SLOTS-1:0]  capacity
);

    logic [SLOTS-1:0] cap_nxt;

    always_comb begin
        cap_nxt = capacity;
        if (rel)
            cap_nxt[rel_slot] = 1'b1;
        // Claim applied last so it wins on a same-slot collision.
        if (claim)
            cap_nxt[claim_slot] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            capacity <= {SLOTS{1'b1}};
        else
            capacity <= cap_nxt;
    end

endmodule

// File: rtl/exit_controller.sv
// exit_controller: owns the parking free-slot bitmap and sequences car exits.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   exit, exit_slot          - exit request, sampled only while idle
//   entry_claim, entry_slot  - one-cycle pulse marking entry_slot occupied
//   parking_capacity         - free-slot bitmap (1 = free)
//   gate_open                - exit gate drive, high GATE_CYCLES cycles
//   exit_done                - pulse when the slot has been freed
//   exit_error               - pulse when the exit slot was already free
//   busy                     - high whenever the FSM is not idle
// Every output is a register; the FSM sets each one on the edge that enters
// the state it belongs to, so the outputs line up with the state register.
module exit_controller
    import parking_pkg::*;
#(
    parameter int SLOTS       = parking_pkg::SLOTS,
    parameter int GATE_CYCLES = parking_pkg::GATE_CYCLES,
    parameter int SLOT_W      = parking_pkg::SLOT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exit,
    input  logic [SLOT_W-1:0] exit_slot,
    input  logic              entry_claim,
    input  logic [SLOT_W-1:0] entry_slot,
    output logic [SLOTS-1:0]  parking_capacity,
    output logic              gate_open,
    output logic              exit_done,
    output logic              exit_error,
    output logic              busy
);

    localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    exit_state_t       state;
    logic [SLOT_W-1:0] slot_q;
    logic [CNT_W-1:0]  cnt;
    logic              release_now;

    // The bitmap update for the exit lands on the same edge that raises
    // exit_done, i.e. the edge taken while in RELEASE.
    assign release_now = (state == RELEASE);

    slot_register #(
        .SLOTS  (SLOTS),
        .SLOT_W (SLOT_W)
    ) u_slots (
        .clk        (clk),
        .rst        (rst),
        .rel        (release_now),
        .rel_slot   (slot_q),
        .claim      (entry_claim),
        .claim_slot (entry_slot),
        .capacity   (parking_capacity)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            slot_q     <= '0;
            cnt        <= '0;
            gate_open  <= 1'b0;
            exit_done  <= 1'b0;
            exit_error <= 1'b0;
            busy       <= 1'b0;
        end else begin
            exit_done  <= 1'b0;
            exit_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (exit) begin
                        slot_q <= exit_slot;
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (parking_capacity[slot_q]) begin
                        // Nothing parked there: reject without touching the gate.
                        exit_error <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt       <= CNT_W'(GATE_CYCLES - 1);
                        gate_open <= 1'b1;
                        state     <= OPEN;
                    end
                end
                OPEN: begin
                    if (cnt == '0) begin
                        gate_open <= 1'b0;
                        state     <= RELEASE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    exit_done <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exit_controller.sv
module tb_exit_controller;

    localparam int SLOTS = 8;
    localparam int SLOT_W = 3;
    localparam int GATE = 4;

    typedef struct {
        bit              err;
        logic [SLOTS-1:0] cap;
        int              lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              exit;
    logic [SLOT_W-1:0] exit_slot;
    logic              entry_claim;
    logic [SLOT_W-1:0] entry_slot;
    logic [SLOTS-1:0]  parking_capacity;
    logic              gate_open, exit_done, exit_error, busy;

    int vectors = 0;
    int miscompares = 0;
    logic [SLOTS-1:0] model_cap;
    exp_t sb[$];

    exit_controller #(.SLOTS(SLOTS), .GATE_CYCLES(GATE), .SLOT_W(SLOT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .exit             (exit),
        .exit_slot        (exit_slot),
        .entry_claim      (entry_claim),
        .entry_slot       (entry_slot),
        .parking_capacity (parking_capacity),
        .gate_open        (gate_open),
        .exit_done        (exit_done),
        .exit_error       (exit_error),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic claim(input int s);
        entry_claim = 1'b1;
        entry_slot  = SLOT_W'(s);
        @(negedge clk);
        entry_claim = 1'b0;
        model_cap[s] = 1'b0;
        chk("claim_cap", 32'(parking_capacity), 32'(model_cap));
    endtask

    // One exit transaction. ovl >= 0 issues a second exit while the gate is
    // open; relc >= 0 pulses entry_claim on that slot during RELEASE.
    task automatic exit_txn(input string tag, input int s, input int ovl, input int relc);
        exp_t e;
        exp_t got;
        int   gates = 0;
        int   outs = 0;
        e.err = model_cap[s];
        e.cap = model_cap;
        if (!e.err) begin
            e.cap[s] = 1'b1;
            if (relc >= 0) e.cap[relc] = 1'b0;
        end
        e.lat = e.err ? 1 : GATE + 2;
        sb.push_back(e);
        model_cap = e.cap;

        exit = 1'b1;
        exit_slot = SLOT_W'(s);
        @(negedge clk);
        exit = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (gate_open) gates++;
            if (exit_done || exit_error) begin
                outs++;
                if (sb.size() == 0) begin
                    chk({tag, "_unexpected_out"}, 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk({tag, "_kind_err"}, 32'(exit_error), 32'(got.err));
                    chk({tag, "_latency"}, j, got.lat);
                    chk({tag, "_cap"}, 32'(parking_capacity), 32'(got.cap));
                end
            end
            if (ovl >= 0 && j == 1) begin exit = 1'b1; exit_slot = SLOT_W'(ovl); end
            if (ovl >= 0 && j == 2) exit = 1'b0;
            if (relc >= 0 && !e.err && j == GATE + 1) begin
                entry_claim = 1'b1; entry_slot = SLOT_W'(relc);
            end
            if (j == GATE + 2) entry_claim = 1'b0;
        end
        chk({tag, "_out_pulses"}, outs, 1);
        chk({tag, "_gate_cycles"}, gates, e.err ? 0 : GATE);
        chk({tag, "_sb_drained"}, sb.size(), 0);
        chk({tag, "_final_cap"}, 32'(parking_capacity), 32'(model_cap));
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; exit = 1'b0; exit_slot = '0; entry_claim = 1'b0; entry_slot = '0;
        model_cap = '1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_cap", 32'(parking_capacity), 32'hFF);
        chk("rst_gate", 32'(gate_open), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", 32'({exit_done, exit_error}), 32'd0);

        claim(0); claim(4); claim(5); claim(7);
        chk("claims_cap", 32'(parking_capacity), 32'h4E);
        claim(0);                                  // already occupied: no change

        exit_txn("exit7", 7, -1, -1);
        chk("exit7_cap_const", 32'(parking_capacity), 32'hCE);
        exit_txn("exit1_err", 1, -1, -1);
        exit_txn("exit0_ovl", 0, 4, -1);
        chk("ovl_cap_const", 32'(parking_capacity), 32'hCF);
        exit_txn("rel4_claim4", 4, -1, 4);
        chk("same_slot_cap", 32'(parking_capacity), 32'hCF);
        exit_txn("rel4_claim2", 4, -1, 2);
        chk("diff_slot_cap", 32'(parking_capacity), 32'hDB);

        // Reset in the middle of OPEN.
        exit = 1'b1; exit_slot = 3'd5;
        @(negedge clk);
        exit = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("pre_rst_gate", 32'(gate_open), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_cap = '1;
        chk("mid_rst_gate", 32'(gate_open), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cap", 32'(parking_capacity), 32'hFF);
        done_seen = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (exit_done || gate_open) done_seen++;
        end
        chk("mid_rst_no_done", done_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
